// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction memory read port, fetch-to-decode handshake
// and the decode/execute redirect inputs.
interface inst_fetch_if;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [15:0] PC_out;
    logic        valid_f;
    logic        en_ctrl;
    logic        jvalid;
    logic [15:0] jloc;
    logic        br_valid;
    logic [15:0] br_target;

    modport master (
        output imem_en, imem_addr, instr, PC_out, valid_f,
        input  imem_rdata, en_ctrl, jvalid, jloc, br_valid, br_target
    );

    modport slave (
        input  imem_en, imem_addr, instr, PC_out, valid_f,
        output imem_rdata, en_ctrl, jvalid, jloc, br_valid, br_target
    );
endinterface

// File: rtl/inst_fetch.sv
// Fetch stage: issues reads to a 1-cycle synchronous instruction memory and
// buffers returned words in a 2-entry queue feeding decode.
module inst_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd1
) (
    input  logic        clk,
    input  logic        rst,
    inst_fetch_if.master bus
);
    logic [15:0] pc;
    logic [15:0] inflight_pc;
    logic        inflight;
    logic [1:0]  occ;
    logic [15:0] head_instr, head_pc;
    logic [15:0] tail_instr, tail_pc;

    logic        redirect;
    logic [15:0] target;
    logic        deq;
    logic        enq;
    logic [2:0]  pending;
    logic        issue;

    always_comb begin
        redirect = bus.br_valid | bus.jvalid;
        target   = bus.br_valid ? bus.br_target : bus.jloc;

        bus.valid_f = (occ != 2'd0);
        bus.instr   = bus.valid_f ? head_instr : 16'h0000;
        bus.PC_out  = bus.valid_f ? head_pc    : 16'h0000;

        deq = bus.valid_f & bus.en_ctrl;
        // The response arriving in a redirect cycle belongs to the old stream;
        // it is dropped here and the target read returns next cycle.
        enq = inflight & ~redirect;

        pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};
        issue   = ~rst & (redirect | (pending < 3'd2));

        bus.imem_en   = issue;
        bus.imem_addr = rst ? 16'h0000 : (redirect ? target : pc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 16'h0000;
            occ         <= 2'd0;
            head_instr  <= 16'h0000;
            head_pc     <= 16'h0000;
            tail_instr  <= 16'h0000;
            tail_pc     <= 16'h0000;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= bus.imem_addr;
                pc          <= bus.imem_addr + PC_STEP;
            end

            if (redirect) begin
                occ <= 2'd0;
            end else begin
                case ({enq, deq})
                    2'b01: begin
                        head_instr <= tail_instr;
                        head_pc    <= tail_pc;
                        occ        <= occ - 2'd1;
                    end
                    2'b10: begin
                        if (occ == 2'd0) begin
                            head_instr <= bus.imem_rdata;
                            head_pc    <= inflight_pc;
                        end else begin
                            tail_instr <= bus.imem_rdata;
                            tail_pc    <= inflight_pc;
                        end
                        occ <= occ + 2'd1;
                    end
                    2'b11: begin
                        if (occ == 2'd1) begin
                            head_instr <= bus.imem_rdata;
                            head_pc    <= inflight_pc;
                        end else begin
                            head_instr <= tail_instr;
                            head_pc    <= tail_pc;
                            tail_instr <= bus.imem_rdata;
                            tail_pc    <= inflight_pc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: per-cycle vector table with hand-computed
// expectations, plus a bounded reset-latency sequence.
module tb_inst_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    inst_fetch_if bus();

    inst_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory holds mem[k] = 16'h1000 + k, one-cycle read latency.
    always_ff @(posedge clk)
        bus.imem_rdata <= bus.imem_en ? (16'h1000 + bus.imem_addr) : 16'hDEAD;

    typedef struct {
        logic        rst;
        logic        en_ctrl;
        logic        jvalid;
        logic [15:0] jloc;
        logic        br_valid;
        logic [15:0] br_target;
        logic        chk_out;
        logic        exp_valid;
        logic [15:0] exp_pc;
        logic        exp_en;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic e, logic jv, logic [15:0] jl,
                                logic bv, logic [15:0] bt, logic co, logic ev,
                                logic [15:0] ep, logic een, logic [15:0] ea);
        vec_t v;
        v.rst = r; v.en_ctrl = e; v.jvalid = jv; v.jloc = jl;
        v.br_valid = bv; v.br_target = bt; v.chk_out = co;
        v.exp_valid = ev; v.exp_pc = ep; v.exp_en = een; v.exp_addr = ea;
        return v;
    endfunction

    task automatic check16(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [15:0] exp_instr;
        int lat;

        bus.en_ctrl = 1'b1; bus.jvalid = 1'b0; bus.jloc = '0;
        bus.br_valid = 1'b0; bus.br_target = '0;

        // rst en jv jloc bv btgt chk valid pc en addr
        vecs.push_back(mk(1,1,0,16'h0,0,16'h0, 1,0,16'h0000, 0,16'h0000));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,0,16'h0000, 1,16'h0000));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,0,16'h0000, 1,16'h0001));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0000, 1,16'h0002));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0001, 1,16'h0003));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0002, 1,16'h0004));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,0,16'h0,0,16'h0, 1,1,16'h0003, 0,16'h0000));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0003, 1,16'h0005));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0004, 1,16'h0006));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0005, 1,16'h0007));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0006, 1,16'h0008));
        vecs.push_back(mk(0,1,1,16'h0040,0,16'h0, 1,1,16'h0007, 1,16'h0040));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,0,16'h0000, 1,16'h0041));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0040, 1,16'h0042));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0041, 1,16'h0043));
        vecs.push_back(mk(0,1,1,16'h0040,1,16'h0100, 1,1,16'h0042, 1,16'h0100));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,0,16'h0000, 1,16'h0101));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0100, 1,16'h0102));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0101, 1,16'h0103));
        vecs.push_back(mk(0,1,0,16'h0,1,16'hFFFE, 1,1,16'h0102, 1,16'hFFFE));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,0,16'h0000, 1,16'hFFFF));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'hFFFE, 1,16'h0000));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'hFFFF, 1,16'h0001));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0000, 1,16'h0002));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0001, 1,16'h0003));
        vecs.push_back(mk(0,0,1,16'h0200,0,16'h0, 1,1,16'h0002, 1,16'h0200));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,0,16'h0000, 1,16'h0201));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0200, 1,16'h0202));
        vecs.push_back(mk(0,1,1,16'h0300,0,16'h0, 1,1,16'h0201, 1,16'h0300));
        vecs.push_back(mk(0,1,0,16'h0,1,16'h0400, 1,0,16'h0000, 1,16'h0400));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,0,16'h0000, 1,16'h0401));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0400, 1,16'h0402));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0401, 1,16'h0403));
        vecs.push_back(mk(0,0,0,16'h0,0,16'h0, 1,1,16'h0402, 0,16'h0000));
        vecs.push_back(mk(1,0,0,16'h0,0,16'h0, 0,0,16'h0000, 0,16'h0000));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,0,16'h0000, 1,16'h0000));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,0,16'h0000, 1,16'h0001));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0000, 1,16'h0002));
        vecs.push_back(mk(0,1,0,16'h0,0,16'h0, 1,1,16'h0001, 1,16'h0003));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst           = vecs[i].rst;
            bus.en_ctrl   = vecs[i].en_ctrl;
            bus.jvalid    = vecs[i].jvalid;
            bus.jloc      = vecs[i].jloc;
            bus.br_valid  = vecs[i].br_valid;
            bus.br_target = vecs[i].br_target;
            @(negedge clk);
            if (vecs[i].chk_out) begin
                exp_instr = vecs[i].exp_valid ? (16'h1000 + vecs[i].exp_pc) : 16'h0000;
                check16($sformatf("valid_f[%0d]", i), {15'b0, bus.valid_f}, {15'b0, vecs[i].exp_valid});
                check16($sformatf("PC_out[%0d]", i), bus.PC_out, vecs[i].exp_pc);
                check16($sformatf("instr[%0d]", i), bus.instr, exp_instr);
            end
            check16($sformatf("imem_en[%0d]", i), {15'b0, bus.imem_en}, {15'b0, vecs[i].exp_en});
            if (vecs[i].exp_en)
                check16($sformatf("imem_addr[%0d]", i), bus.imem_addr, vecs[i].exp_addr);
        end

        // Mid-stream reset, then bounded wait for the first valid word.
        @(posedge clk); #1;
        rst = 1'b1; bus.en_ctrl = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; bus.en_ctrl = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!bus.valid_f && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check16("reset_latency", 16'(lat), 16'd2);
        check16("reset_first_pc", bus.PC_out, 16'h0000);
        check16("reset_first_instr", bus.instr, 16'h1000);
        @(negedge clk);
        check16("reset_second_pc", bus.PC_out, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
